piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in, serial-out shift transmitter with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word and emits it one bit per accepted beat, MSB first.
- It is the transmit end for the team's serial-in left-shift receiver. That receiver shifts each new bit into the LSB, so after WIDTH beats the first bit sent lands in the MSB and the word is reconstructed unchanged.

Parameters:
- WIDTH, 4, parallel word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting rst=0 clears all state immediately; release is sampled synchronously to clk.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  downstream accepts sout this cycle.
- sout_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state SHIFT).

Behaviour:
- Reset values (rst=0): state=IDLE, shreg=0, bit counter=0, sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=1.
- State IDLE:
  - load_ready=1, sout_valid=0.
  - On load_valid && load_ready at an edge: shreg <= load_data, cnt <= 0, state -> SHIFT.
- State SHIFT:
  - sout = shreg[WIDTH-1]; sout_valid=1; busy=1.
  - sout_last=1 when cnt == WIDTH-1.
- Beat = sout_valid && sout_ready. On a beat that is not last: shreg <= {shreg[WIDTH-2:0], 1'b0}, cnt <= cnt+1.
- No beat (sout_ready=0): shreg, cnt, sout and sout_last all hold. The bit is never dropped or duplicated.
- Last beat:
  - If load_valid is also high: load_ready=1 in that cycle, so the new word loads at the same edge and the next frame starts with no bubble (state stays SHIFT, cnt <= 0).
  - Otherwise state -> IDLE.
- load_ready = (state==IDLE) || (sout_last && sout_ready). It is combinational from registered state and sout_ready.
- load_valid while SHIFT and not on the last beat: ignored; load_data is not sampled.
- Latency: word accepted at edge N means its MSB appears on sout in the cycle after edge N. An unstalled frame occupies exactly WIDTH cycles.
- Counter width: $clog2(WIDTH+1) bits. It never exceeds WIDTH-1 (or WIDTH with parity) and never wraps.
- Reset mid-frame: the frame is aborted at once and outputs return to reset values. No partial bits are emitted after rst deasserts.
- sout is driven from the shreg MSB only; no glitch path from inputs.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of the loaded word) is captured at load.
  - It is sent as one extra beat after the LSB, so a frame is WIDTH+1 beats.
  - sout_last asserts on the parity beat, not on the LSB; the counter limit becomes WIDTH.
- When undefined: no parity register and no extra beat; frame = WIDTH beats, exactly as above.

Decomposition:
- Shared package piso_pkg holds:
  - state enum (IDLE=1'b0, SHIFT=1'b1);
  - a localparam function computing the counter width from WIDTH.
- One natural sub-module: piso_bit_counter (load/clear, enable, terminal-count flag), reusable by the receiver side.
- The shift register and FSM stay in the top.

Test Plan:
- WIDTH=4, load 4'b1101, sout_ready=1 → sout 1,1,0,1 on 4 consecutive cycles; sout_last high only on the 4th; returns to IDLE with load_ready=1.
- Back-to-back: 4'b1010 then 4'b0011 with load_valid held → 8 contiguous bits 1,0,1,0,0,0,1,1, no sout_valid gap; second load accepted on the first frame's last beat.
- Backpressure: load 4'b1001, drop sout_ready for 3 cycles after the first bit → sout holds 0 stable across the stall; stream completes 1,0,0,1.
- Load while busy: pulse load_valid with 4'b1111 mid-frame of 4'b0100 → ignored; output is 0,1,0,0 only.
- Reset: assert rst=0 during the 2nd bit of 4'b1110 → sout_valid=0, busy=0 immediately; after release, a fresh load of 4'b0110 transmits correctly.
- PISO_PARITY_EN defined: load 4'b1011 → sout 1,0,1,1,1 (parity=1), sout_last on the 5th beat; load 4'b0000 → parity beat 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_shift_tx transmitter and its companion receiver.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width; sized to hold WIDTH so the parity build fits too.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Beat counter with synchronous clear, count enable and terminal-count flag at LIMIT.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int CW    = 3,
    parameter int LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LIM);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB first, valid/ready on both sides.
// Optional macro PISO_PARITY_EN appends an even-parity beat after the LSB.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    w_cnt;
    logic             w_tc;
    logic             w_beat;
    logic             w_last;
    logic             w_load;
    logic             w_fill;

`ifdef PISO_PARITY_EN
    logic r_par;

    // Shifting the parity bit in from the bottom lands it in the MSB right after the LSB.
    assign w_fill = r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^load_data;
        end
    end
`else
    assign w_fill = 1'b0;
`endif

    assign sout_valid = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign sout       = r_shreg[WIDTH-1];
    assign w_last     = (r_state == SHIFT) && w_tc;
    assign sout_last  = w_last;
    assign w_beat     = sout_valid && sout_ready;
    assign load_ready = (r_state == IDLE) || (w_last && sout_ready);
    assign w_load     = load_valid && load_ready;

    piso_bit_counter #(
        .CW    (CW),
        .LIMIT (LAST_IDX)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_load || (w_beat && w_last)),
        .i_en    (w_beat && !w_last),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_shreg <= load_data;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_beat) begin
                        if (!w_last) begin
                            r_shreg <= {r_shreg[WIDTH-2:0], w_fill};
                        end else if (load_valid) begin
                            r_shreg <= load_data;
                        end else begin
                            r_shreg <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: queue-based reference model plus directed literal checks.
module tb_piso_shift_tx;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         sout;
    logic         sout_valid;
    logic         sout_ready = 1'b0;
    logic         sout_last;
    logic         busy;

    int total = 0;
    int bad   = 0;

    bit mq[$];
    bit got[$];
    int last_cnt;

    piso_shift_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Reference: a frame is just a queue of bits to be delivered, MSB first.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            bit beat;
            bit lr;
            beat = (mq.size() != 0) && sout_ready;
            lr   = (mq.size() == 0) || ((mq.size() == 1) && sout_ready);
            if (beat) void'(mq.pop_front());
            if (load_valid && lr) begin
                for (int i = W - 1; i >= 0; i--) mq.push_back(load_data[i]);
`ifdef PISO_PARITY_EN
                mq.push_back(^load_data);
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("load_ready", load_ready, (mq.size() == 0) || ((mq.size() == 1) && sout_ready));
        check("sout_valid", sout_valid, mq.size() != 0);
        check("busy", busy, mq.size() != 0);
        check("sout_last", sout_last, mq.size() == 1);
        if (mq.size() != 0) check("sout", sout, mq[0]);
        if (sout_valid && sout_ready && rst) begin
            got.push_back(sout);
            if (sout_last) last_cnt++;
        end
    end

    task automatic send(input logic [W-1:0] w);
        bit ok = 0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        got.delete();
        last_cnt = 0;
    endtask

    initial begin
        #2;
        check("rst_load_ready", load_ready, 1);
        check("rst_sout", sout, 0);
        check("rst_sout_valid", sout_valid, 0);
        check("rst_sout_last", sout_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        sout_ready = 1'b1;

        // Single frame 1101
        begin_test();
        send(4'b1101);
        load_valid = 1'b0;
        settle();
`ifdef PISO_PARITY_EN
        check("t1_bits", pack(got), 32'b11011);
`else
        check("t1_bits", pack(got), 32'b1101);
`endif
        check("t1_len", got.size(), FL);
        check("t1_last", last_cnt, 1);
        check("t1_idle_ready", load_ready, 1);

        // Back-to-back 1010, 0011
        begin_test();
        send(4'b1010);
        send(4'b0011);
        load_valid = 1'b0;
        settle();
`ifdef PISO_PARITY_EN
        check("t2_bits", pack(got), 32'b1010000110);
`else
        check("t2_bits", pack(got), 32'b10100011);
`endif
        check("t2_len", got.size(), 2 * FL);
        check("t2_last", last_cnt, 2);

        // Backpressure on 1001 after first bit
        begin_test();
        send(4'b1001);
        load_valid = 1'b0;
        @(posedge clk);
        #1 sout_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3_hold_bit", sout, 0);
            check("t3_hold_valid", sout_valid, 1);
        end
        @(posedge clk);
        #1 sout_ready = 1'b1;
        settle();
`ifdef PISO_PARITY_EN
        check("t3_bits", pack(got), 32'b10010);
`else
        check("t3_bits", pack(got), 32'b1001);
`endif
        check("t3_len", got.size(), FL);

        // Load pulse mid-frame is ignored
        begin_test();
        send(4'b0100);
        load_valid = 1'b0;
        @(posedge clk);
        #1 load_valid = 1'b1;
        load_data = 4'b1111;
        @(posedge clk);
        #1 load_valid = 1'b0;
        settle();
`ifdef PISO_PARITY_EN
        check("t4_bits", pack(got), 32'b01001);
`else
        check("t4_bits", pack(got), 32'b0100);
`endif
        check("t4_len", got.size(), FL);

        // Reset during the second bit of 1110
        send(4'b1110);
        load_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5_valid_now", sout_valid, 0);
        check("t5_busy_now", busy, 0);
        check("t5_ready_now", load_ready, 1);
        check("t5_sout_now", sout, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        begin_test();
        repeat (3) @(negedge clk);
        check("t5_no_stale", got.size(), 0);
        @(posedge clk);
        #1;
        send(4'b0110);
        load_valid = 1'b0;
        settle();
`ifdef PISO_PARITY_EN
        check("t5_bits", pack(got), 32'b01100);
`else
        check("t5_bits", pack(got), 32'b0110);
`endif

`ifdef PISO_PARITY_EN
        begin_test();
        send(4'b1011);
        send(4'b0000);
        load_valid = 1'b0;
        settle();
        check("tp_bits", pack(got), 32'b1011100000);
`endif

        // Randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 1500; c++) begin
            load_valid = ($urandom_range(0, 99) < 40);
            load_data  = W'($urandom);
            sout_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst = 1'b0;
                @(posedge clk);
                #1 rst = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        load_valid = 1'b0;
        sout_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("final_idle", sout_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
